// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// opcode values, ALU operation encodings and the decoded-control bundle.
package cpu_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Opcodes carried in instruction bits [7:4]; 0x7..0xE are illegal.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_OUT = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU operation select presented to the datapath (2'b11 is reserved).
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  // Control produced by the opcode decoder for one instruction.
  typedef struct packed {
    logic       pc_inc;
    logic       pc_load;
    logic       acc_load;
    logic       led_load;
    logic [1:0] alu_op;
    logic       illegal;
    logic       halt;
  } dec_t;

  // Four-bit increment that sticks at 0xF instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder: maps an opcode (plus the zero flag for JZ)
// to the one-cycle strobes, ALU select and status bits used in EXEC.
import cpu_pkg::*;

module seq_decode (
  input  logic [3:0] opcode,
  input  logic       zero,
  output dec_t       dec
);

  // Opcode table; every path yields at most one of pc_load/acc_load/led_load
  // and never pc_inc together with pc_load.
  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_PASS;
    case (opcode)
      OP_NOP: dec.pc_inc = 1'b1;
      OP_LDI: begin
        dec.acc_load = 1'b1;
        dec.alu_op   = ALU_PASS;
        dec.pc_inc   = 1'b1;
      end
      OP_ADD: begin
        dec.acc_load = 1'b1;
        dec.alu_op   = ALU_ADD;
        dec.pc_inc   = 1'b1;
      end
      OP_SUB: begin
        dec.acc_load = 1'b1;
        dec.alu_op   = ALU_SUB;
        dec.pc_inc   = 1'b1;
      end
      OP_JMP: dec.pc_load = 1'b1;
      OP_JZ: begin
        dec.pc_load = zero;
        dec.pc_inc  = !zero;
      end
      OP_OUT: begin
        dec.led_load = 1'b1;
        dec.pc_inc   = 1'b1;
      end
      OP_HLT: dec.halt = 1'b1;
      default: begin
        dec.pc_inc  = 1'b1;
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: FETCH/DECODE/EXEC loop with a fetch timeout,
// sticky status flags and fully registered (Moore) control outputs.
import cpu_pkg::*;

module cpu_sequencer #(
  parameter int TIMEOUT      = 8,
  parameter bit IDLE_ON_STOP = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       run,
  input  logic       mem_ready,
  input  logic [7:0] mem_data,
  input  logic       zero,
  output logic       mem_rd,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_load,
  output logic [1:0] alu_op,
  output logic [3:0] imm,
  output logic       led_load,
  output logic       halted,
  output logic       fault,
  output logic       illegal
);

  localparam logic [3:0] TIMEOUT_LIM = 4'(TIMEOUT);

  state_t     state_reg;
  logic [7:0] ir_reg;
  logic [3:0] wait_cnt_reg;
  logic [3:0] wait_cnt_inc;
  logic       mem_rd_reg;
  logic       pc_inc_reg;
  logic       pc_load_reg;
  logic       acc_load_reg;
  logic       led_load_reg;
  logic [1:0] alu_op_reg;
  logic [3:0] imm_reg;
  logic       halted_reg;
  logic       fault_reg;
  logic       illegal_reg;
  dec_t       dec;

  // Decode is driven from the latched instruction, so it is stable
  // throughout DECODE and EXEC regardless of what the memory bus does.
  seq_decode u_decode (
    .opcode (ir_reg[7:4]),
    .zero   (zero),
    .dec    (dec)
  );

  assign wait_cnt_inc = sat_inc4(wait_cnt_reg);

  // Sequencer FSM; outputs are registered alongside the state so each one
  // reflects the state being entered. The zero flag is taken on the
  // DECODE->EXEC edge so the JZ strobe lands inside the EXEC cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      ir_reg       <= 8'h00;
      wait_cnt_reg <= 4'd0;
      mem_rd_reg   <= 1'b0;
      pc_inc_reg   <= 1'b0;
      pc_load_reg  <= 1'b0;
      acc_load_reg <= 1'b0;
      led_load_reg <= 1'b0;
      alu_op_reg   <= ALU_PASS;
      imm_reg      <= 4'd0;
      halted_reg   <= 1'b0;
      fault_reg    <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      // Strobes are single-cycle: they only survive the EXEC cycle.
      pc_inc_reg   <= 1'b0;
      pc_load_reg  <= 1'b0;
      acc_load_reg <= 1'b0;
      led_load_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (run) begin
            state_reg    <= ST_FETCH;
            mem_rd_reg   <= 1'b1;
            wait_cnt_reg <= 4'd0;
          end
        end
        ST_FETCH: begin
          if (mem_ready) begin
            ir_reg     <= mem_data;
            state_reg  <= ST_DECODE;
            mem_rd_reg <= 1'b0;
          end else if (wait_cnt_inc >= TIMEOUT_LIM) begin
            wait_cnt_reg <= wait_cnt_inc;
            state_reg    <= ST_HALT;
            mem_rd_reg   <= 1'b0;
            fault_reg    <= 1'b1;
            halted_reg   <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_inc;
          end
        end
        ST_DECODE: begin
          state_reg    <= ST_EXEC;
          imm_reg      <= ir_reg[3:0];
          alu_op_reg   <= dec.alu_op;
          pc_inc_reg   <= dec.pc_inc;
          pc_load_reg  <= dec.pc_load;
          acc_load_reg <= dec.acc_load;
          led_load_reg <= dec.led_load;
          if (dec.illegal) begin
            illegal_reg <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (dec.halt) begin
            state_reg  <= ST_HALT;
            halted_reg <= 1'b1;
          end else if (run || !IDLE_ON_STOP) begin
            state_reg    <= ST_FETCH;
            mem_rd_reg   <= 1'b1;
            wait_cnt_reg <= 4'd0;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_HALT: begin
          state_reg <= ST_HALT;
        end
        default: begin
          state_reg  <= ST_IDLE;
          mem_rd_reg <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd   = mem_rd_reg;
  assign pc_inc   = pc_inc_reg;
  assign pc_load  = pc_load_reg;
  assign acc_load = acc_load_reg;
  assign led_load = led_load_reg;
  assign alu_op   = alu_op_reg;
  assign imm      = imm_reg;
  assign halted   = halted_reg;
  assign fault    = fault_reg;
  assign illegal  = illegal_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction walk-through, fetch timeout,
// illegal/halt behaviour, asynchronous reset in EXEC and run drop in DECODE.
`timescale 1ns/1ps

module tb_cpu_sequencer;

  logic       CLK;
  logic       RST_N;
  logic       run;
  logic       mem_ready;
  logic [7:0] mem_data;
  logic       zero;
  logic       mem_rd;
  logic       pc_inc;
  logic       pc_load;
  logic       acc_load;
  logic [1:0] alu_op;
  logic [3:0] imm;
  logic       led_load;
  logic       halted;
  logic       fault;
  logic       illegal;

  int checks_cnt;
  int fail_cnt;
  int rd_cycles;

  // {pc_inc, pc_load, acc_load, led_load}
  logic [3:0] strb;
  // every 1-bit output: {mem_rd, strb, halted, fault, illegal}
  logic [7:0] flags;
  assign strb  = {pc_inc, pc_load, acc_load, led_load};
  assign flags = {mem_rd, strb, halted, fault, illegal};

  cpu_sequencer dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .run       (run),
    .mem_ready (mem_ready),
    .mem_data  (mem_data),
    .zero      (zero),
    .mem_rd    (mem_rd),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .acc_load  (acc_load),
    .alu_op    (alu_op),
    .imm       (imm),
    .led_load  (led_load),
    .halted    (halted),
    .fault     (fault),
    .illegal   (illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one instruction starting just after FETCH was entered.
  task automatic do_instr(input string tag, input logic [7:0] data, input logic z,
                          input logic [3:0] exp_strb, input logic [1:0] exp_alu,
                          input logic [3:0] exp_imm, input logic exp_ill,
                          input logic exp_rd_after, input logic exp_halt_after);
    mem_data  = data;
    mem_ready = 1'b1;
    zero      = z;
    tick();
    check_eq({tag, ".dec_rd"}, 16'(mem_rd), 16'(1'b0));
    // Bus activity outside FETCH must not disturb the latched instruction.
    mem_data = 8'hEE;
    tick();
    check_eq({tag, ".strb"}, 16'(strb), 16'(exp_strb));
    check_eq({tag, ".alu"}, 16'(alu_op), 16'(exp_alu));
    check_eq({tag, ".imm"}, 16'(imm), 16'(exp_imm));
    check_eq({tag, ".ill"}, 16'(illegal), 16'(exp_ill));
    mem_ready = 1'b0;
    tick();
    check_eq({tag, ".next_rd"}, 16'(mem_rd), 16'(exp_rd_after));
    check_eq({tag, ".next_strb"}, 16'(strb), 16'h0);
    check_eq({tag, ".halted"}, 16'(halted), 16'(exp_halt_after));
    $display("txn %s data=%02h zero=%0b strb=%04b alu=%0d imm=%0h", tag, data, z, exp_strb, exp_alu, exp_imm);
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    RST_N      = 1'b0;
    run        = 1'b0;
    mem_ready  = 1'b0;
    mem_data   = 8'h00;
    zero       = 1'b0;
    tick();
    tick();
    check_eq("rst.flags", 16'(flags), 16'h0);
    check_eq("rst.imm", 16'(imm), 16'h0);
    check_eq("rst.alu", 16'(alu_op), 16'h0);

    // Program walk-through with run held high.
    RST_N = 1'b1;
    run   = 1'b1;
    tick();
    check_eq("start.rd", 16'(mem_rd), 16'h1);
    //        tag     data   z     strb     alu    imm   ill   rd    halt
    do_instr("ldi5",  8'h15, 1'b0, 4'b1010, 2'b00, 4'h5, 1'b0, 1'b1, 1'b0);
    do_instr("ldi3",  8'h13, 1'b0, 4'b1010, 2'b00, 4'h3, 1'b0, 1'b1, 1'b0);
    do_instr("jz_n",  8'h52, 1'b0, 4'b1000, 2'b00, 4'h2, 1'b0, 1'b1, 1'b0);
    do_instr("jz_y",  8'h52, 1'b1, 4'b0100, 2'b00, 4'h2, 1'b0, 1'b1, 1'b0);
    do_instr("add",   8'h27, 1'b0, 4'b1010, 2'b01, 4'h7, 1'b0, 1'b1, 1'b0);
    do_instr("sub",   8'h31, 1'b0, 4'b1010, 2'b10, 4'h1, 1'b0, 1'b1, 1'b0);
    do_instr("jmp",   8'h4C, 1'b1, 4'b0100, 2'b00, 4'hC, 1'b0, 1'b1, 1'b0);
    do_instr("out",   8'h60, 1'b0, 4'b1001, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
    do_instr("ill9",  8'h9A, 1'b0, 4'b1000, 2'b00, 4'hA, 1'b1, 1'b1, 1'b0);
    do_instr("nop",   8'h00, 1'b0, 4'b1000, 2'b00, 4'h0, 1'b1, 1'b1, 1'b0);
    do_instr("hlt",   8'hF0, 1'b0, 4'b0000, 2'b00, 4'h0, 1'b1, 1'b0, 1'b1);

    // HALT ignores run and the memory bus.
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      tick();
      check_eq("halt.flags", 16'(flags), 16'b0000_0101);
    end

    // Fetch timeout: mem_ready never arrives.
    RST_N = 1'b0;
    #1;
    check_eq("rst2.flags", 16'(flags), 16'h0);
    tick();
    RST_N     = 1'b1;
    run       = 1'b1;
    mem_ready = 1'b0;
    tick();
    rd_cycles = 0;
    while (mem_rd === 1'b1 && rd_cycles < 20) begin
      rd_cycles++;
      tick();
    end
    check_eq("to.rd_cycles", 16'(rd_cycles), 16'd8);
    check_eq("to.flags", 16'(flags), 16'b0000_0110);
    $display("txn timeout rd_cycles=%0d", rd_cycles);

    // Asynchronous reset in the middle of an OUT execute cycle.
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    mem_data  = 8'h60;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    check_eq("arst.led_pre", 16'(led_load), 16'h1);
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("arst.flags", 16'(flags), 16'h0);
    check_eq("arst.imm", 16'(imm), 16'h0);
    run = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    check_eq("arst.idle1", 16'(flags), 16'h0);
    tick();
    check_eq("arst.idle2", 16'(flags), 16'h0);
    $display("txn async_reset_in_exec");

    // run dropped during DECODE: instruction finishes, then IDLE.
    run = 1'b1;
    tick();
    check_eq("drop.fetch_rd", 16'(mem_rd), 16'h1);
    mem_data  = 8'h1F;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    run       = 1'b0;
    tick();
    check_eq("drop.strb", 16'(strb), 16'b1010);
    check_eq("drop.imm", 16'(imm), 16'hF);
    tick();
    check_eq("drop.idle", 16'(flags), 16'h0);
    tick();
    check_eq("drop.idle2", 16'(mem_rd), 16'h0);
    $display("txn run_drop_in_decode");

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
